// File: rtl/nn_param_loader.sv
// Parameter-stream sequencer for the four-layer network: walks layer/neuron/weight
// counters over one AXI-stream packet and drives the shared weight/bias bus.
module nn_param_loader #(
   parameter int NUM_NEURON_L1 = 30,
   parameter int NUM_NEURON_L2 = 30,
   parameter int NUM_NEURON_L3 = 10,
   parameter int NUM_NEURON_L4 = 10,
   parameter int NUM_WEIGHT_L1 = 784,
   parameter int NUM_WEIGHT_L2 = 30,
   parameter int NUM_WEIGHT_L3 = 30,
   parameter int NUM_WEIGHT_L4 = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_s_axis_data,
   input  logic        i_s_axis_valid,
   input  logic        i_s_axis_last,
   output logic        o_s_axis_ready,
   output logic [31:0] o_weight,
   output logic        o_weight_valid,
   output logic [31:0] o_bias,
   output logic        o_bias_valid,
   output logic [31:0] o_layer_id,
   output logic [31:0] o_neuron_id,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_loaded,
   output logic        o_error
);

   localparam int MAX_N = (NUM_NEURON_L1 > NUM_NEURON_L2 ? NUM_NEURON_L1 : NUM_NEURON_L2) >
                          (NUM_NEURON_L3 > NUM_NEURON_L4 ? NUM_NEURON_L3 : NUM_NEURON_L4) ?
                          (NUM_NEURON_L1 > NUM_NEURON_L2 ? NUM_NEURON_L1 : NUM_NEURON_L2) :
                          (NUM_NEURON_L3 > NUM_NEURON_L4 ? NUM_NEURON_L3 : NUM_NEURON_L4);
   localparam int MAX_W = (NUM_WEIGHT_L1 > NUM_WEIGHT_L2 ? NUM_WEIGHT_L1 : NUM_WEIGHT_L2) >
                          (NUM_WEIGHT_L3 > NUM_WEIGHT_L4 ? NUM_WEIGHT_L3 : NUM_WEIGHT_L4) ?
                          (NUM_WEIGHT_L1 > NUM_WEIGHT_L2 ? NUM_WEIGHT_L1 : NUM_WEIGHT_L2) :
                          (NUM_WEIGHT_L3 > NUM_WEIGHT_L4 ? NUM_WEIGHT_L3 : NUM_WEIGHT_L4);
   localparam int MAX_B = MAX_N > MAX_W ? MAX_N : MAX_W;
   // Layer counter shares the width, so it must still reach 4.
   localparam int CW    = $clog2(MAX_B) > 3 ? $clog2(MAX_B) : 3;

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, DONE, ERROR} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] layer, neuron, widx;
   logic [CW-1:0] w_last, n_last;
   logic          accept, start_ok, final_bias;

   always_comb begin
      w_last = CW'(NUM_WEIGHT_L1 - 1);
      n_last = CW'(NUM_NEURON_L1 - 1);
      case (layer)
         CW'(2): begin w_last = CW'(NUM_WEIGHT_L2 - 1); n_last = CW'(NUM_NEURON_L2 - 1); end
         CW'(3): begin w_last = CW'(NUM_WEIGHT_L3 - 1); n_last = CW'(NUM_NEURON_L3 - 1); end
         CW'(4): begin w_last = CW'(NUM_WEIGHT_L4 - 1); n_last = CW'(NUM_NEURON_L4 - 1); end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      o_s_axis_ready = (state == LOAD_W) || (state == LOAD_B);
      o_busy         = o_s_axis_ready;
      accept         = i_s_axis_valid && o_s_axis_ready;
      start_ok       = i_start && !o_s_axis_ready;
      final_bias     = (neuron == n_last) && (layer == CW'(4));
      case (state)
         IDLE, DONE, ERROR: if (i_start) state_nxt = LOAD_W;
         LOAD_W: if (accept) begin
            if (i_s_axis_last)      state_nxt = ERROR;
            else if (widx == w_last) state_nxt = LOAD_B;
         end
         LOAD_B: if (accept) begin
            if (final_bias)         state_nxt = i_s_axis_last ? DONE : ERROR;
            else if (i_s_axis_last) state_nxt = ERROR;
            else                    state_nxt = LOAD_W;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         layer          <= '0;
         neuron         <= '0;
         widx           <= '0;
         o_weight       <= '0;
         o_weight_valid <= 1'b0;
         o_bias         <= '0;
         o_bias_valid   <= 1'b0;
         o_layer_id     <= '0;
         o_neuron_id    <= '0;
         o_done         <= 1'b0;
         o_loaded       <= 1'b0;
         o_error        <= 1'b0;
      end else begin
         o_weight_valid <= 1'b0;
         o_bias_valid   <= 1'b0;
         o_done         <= 1'b0;
         if (start_ok) begin
            layer    <= CW'(1);
            neuron   <= '0;
            widx     <= '0;
            o_loaded <= 1'b0;
            o_error  <= 1'b0;
         end
         if (accept) begin
            o_layer_id  <= 32'(layer);
            o_neuron_id <= 32'(neuron);
         end
         if (accept && state == LOAD_W) begin
            o_weight       <= i_s_axis_data;
            o_weight_valid <= 1'b1;
            widx           <= (widx == w_last) ? '0 : widx + CW'(1);
         end
         if (accept && state == LOAD_B) begin
            o_bias       <= i_s_axis_data;
            o_bias_valid <= 1'b1;
            if (neuron != n_last) begin
               neuron <= neuron + CW'(1);
            end else if (layer != CW'(4)) begin
               layer  <= layer + CW'(1);
               neuron <= '0;
            end
         end
         if (state_nxt == DONE && state != DONE) begin
            o_done   <= 1'b1;
            o_loaded <= 1'b1;
         end
         if (state_nxt == ERROR && state != ERROR) begin
            o_error  <= 1'b1;
            o_loaded <= 1'b0;
         end
      end
   end

endmodule
